i2s_frame_clock_gen: RTL and testbench

// - Parametrised I2S/TDM master clock generator: derives BCLK and word select/frame sync (WS) from clk.
// - Supports I2S, left-justified (LJ) and TDM frame-sync formats, with configurable slot width and slot count.
// - Emits single-cycle edge strobes and bit/slot indices so serialisers/deserialisers run synchronously in clk.
// - Sits between the codec control path and the audio TX/RX shift registers.

---
 rtl/i2s_pkg.sv | 29 ++
 rtl/i2s_bclk_div.sv | 42 ++++
 rtl/i2s_frame_clock_gen.sv | 109 ++++++++++
 tb/tb_i2s_frame_clock_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: frame formats and index-width helpers shared by the
// I2S/TDM clock generator and its BCLK divider.
package i2s_pkg;

    typedef enum logic [1:0] {
        FMT_I2S = 2'd0,
        FMT_LJ  = 2'd1,
        FMT_TDM = 2'd2
    } fmt_e;

    localparam int HALF_DIV_MIN  = 2;
    localparam int SLOT_BITS_MIN = 8;
    localparam int SLOT_BITS_MAX = 32;
    localparam int NUM_SLOTS_MIN = 2;
    localparam int NUM_SLOTS_MAX = 8;

    function automatic int bit_idx_w(input int slot_bits);
        return (slot_bits > 1) ? $clog2(slot_bits) : 1;
    endfunction

    function automatic int slot_idx_w(input int num_slots);
        return (num_slots > 1) ? $clog2(num_slots) : 1;
    endfunction

    function automatic int half_cnt_w(input int half_div);
        return (half_div > 1) ? $clog2(half_div) : 1;
    endfunction

endpackage

// File: rtl/i2s_bclk_div.sv
// i2s_bclk_div: half-period counter, registered BCLK and its edge strobes.
// fall_next flags the clk edge on which BCLK will drop.
module i2s_bclk_div
    import i2s_pkg::*;
#(
    parameter int HALF_DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bclk,
    output logic bclk_rise,
    output logic bclk_fall,
    output logic fall_next
);

    localparam int HW = half_cnt_w(HALF_DIV);
    localparam logic [HW-1:0] HALF_MAX = HW'(HALF_DIV - 1);

    logic [HW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt       <= '0;
            bclk      <= 1'b0;
            bclk_rise <= 1'b0;
            bclk_fall <= 1'b0;
        end else if (cnt == HALF_MAX) begin
            cnt       <= '0;
            bclk      <= ~bclk;
            bclk_rise <= ~bclk;
            bclk_fall <= bclk;
        end else begin
            cnt       <= cnt + HW'(1);
            bclk_rise <= 1'b0;
            bclk_fall <= 1'b0;
        end
    end

    assign fall_next = (cnt == HALF_MAX) && bclk;

endmodule

// File: rtl/i2s_frame_clock_gen.sv
// i2s_frame_clock_gen: I2S / LJ / TDM master clock generator with
// bit/slot indices and frame strobe, all synchronous to clk.
module i2s_frame_clock_gen
    import i2s_pkg::*;
#(
    parameter int HALF_DIV  = 8,
    parameter int SLOT_BITS = 32,
    parameter int NUM_SLOTS = 2,
    parameter int FMT       = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    output logic                             bclk,
    output logic                             ws,
    output logic                             bclk_rise,
    output logic                             bclk_fall,
    output logic [bit_idx_w(SLOT_BITS)-1:0]  bit_idx,
    output logic [slot_idx_w(NUM_SLOTS)-1:0] slot_idx,
    output logic                             frame_start
);

    localparam int BW = bit_idx_w(SLOT_BITS);
    localparam int SW = slot_idx_w(NUM_SLOTS);
    localparam logic [BW-1:0] BIT_MAX  = BW'(SLOT_BITS - 1);
    localparam logic [SW-1:0] SLOT_MAX = SW'(NUM_SLOTS - 1);
    localparam fmt_e FMT_SEL = fmt_e'(FMT);

    if (HALF_DIV < HALF_DIV_MIN) begin : g_bad_half_div
        $error("i2s_frame_clock_gen: HALF_DIV must be >= 2");
    end
    if (SLOT_BITS < SLOT_BITS_MIN || SLOT_BITS > SLOT_BITS_MAX) begin : g_bad_slot_bits
        $error("i2s_frame_clock_gen: SLOT_BITS must be 8..32");
    end
    if (NUM_SLOTS < NUM_SLOTS_MIN || NUM_SLOTS > NUM_SLOTS_MAX) begin : g_bad_num_slots
        $error("i2s_frame_clock_gen: NUM_SLOTS must be 2..8");
    end
    if (FMT < 0 || FMT > 2) begin : g_bad_fmt
        $error("i2s_frame_clock_gen: FMT must be 0, 1 or 2");
    end
    if (FMT != 2 && NUM_SLOTS != 2) begin : g_bad_fmt_slots
        $error("i2s_frame_clock_gen: I2S/LJ need NUM_SLOTS == 2");
    end

    logic          fall_next;
    logic [BW-1:0] bit_nx;
    logic [SW-1:0] slot_nx;
    logic          wrap;
    logic          ws_nx;

    i2s_bclk_div #(
        .HALF_DIV (HALF_DIV)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .bclk      (bclk),
        .bclk_rise (bclk_rise),
        .bclk_fall (bclk_fall),
        .fall_next (fall_next)
    );

    // MSB-first bit walk; slot advances when the LSB has been sent
    always_comb begin
        bit_nx  = bit_idx;
        slot_nx = slot_idx;
        wrap    = 1'b0;
        if (bit_idx == '0) begin
            bit_nx = BIT_MAX;
            if (slot_idx == SLOT_MAX) begin
                slot_nx = '0;
                wrap    = 1'b1;
            end else begin
                slot_nx = slot_idx + SW'(1);
            end
        end else begin
            bit_nx = bit_idx - BW'(1);
        end
    end

    // WS is derived from the indices that take effect on this fall
    always_comb begin
        ws_nx = 1'b0;
        unique case (FMT_SEL)
            FMT_I2S: ws_nx = slot_nx[0] ^ (bit_nx == '0);
            FMT_LJ:  ws_nx = slot_nx[0];
            FMT_TDM: ws_nx = (slot_nx == SLOT_MAX) && (bit_nx == '0);
            default: ws_nx = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            bit_idx     <= BIT_MAX;
            slot_idx    <= '0;
            ws          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (fall_next) begin
                bit_idx     <= bit_nx;
                slot_idx    <= slot_nx;
                ws          <= ws_nx;
                frame_start <= wrap;
            end
        end
    end

endmodule

// File: tb/tb_i2s_frame_clock_gen.sv
// tb_i2s_frame_clock_gen: three configurations (I2S, LJ, TDM) driven by shared
// random rst/en, checked each cycle against a closed-form timing model.
module tb_i2s_frame_clock_gen;

    logic clk = 1'b0;
    logic rst;
    logic en;

    always #5 clk = ~clk;

    logic       a_bclk, a_ws, a_rise, a_fall, a_fs;
    logic [4:0] a_bit;
    logic [0:0] a_slot;

    logic       b_bclk, b_ws, b_rise, b_fall, b_fs;
    logic [4:0] b_bit;
    logic [0:0] b_slot;

    logic       c_bclk, c_ws, c_rise, c_fall, c_fs;
    logic [3:0] c_bit;
    logic [2:0] c_slot;

    i2s_frame_clock_gen #(
        .HALF_DIV(8), .SLOT_BITS(32), .NUM_SLOTS(2), .FMT(0)
    ) u_i2s (
        .clk(clk), .rst(rst), .en(en),
        .bclk(a_bclk), .ws(a_ws),
        .bclk_rise(a_rise), .bclk_fall(a_fall),
        .bit_idx(a_bit), .slot_idx(a_slot),
        .frame_start(a_fs)
    );

    i2s_frame_clock_gen #(
        .HALF_DIV(8), .SLOT_BITS(32), .NUM_SLOTS(2), .FMT(1)
    ) u_lj (
        .clk(clk), .rst(rst), .en(en),
        .bclk(b_bclk), .ws(b_ws),
        .bclk_rise(b_rise), .bclk_fall(b_fall),
        .bit_idx(b_bit), .slot_idx(b_slot),
        .frame_start(b_fs)
    );

    i2s_frame_clock_gen #(
        .HALF_DIV(2), .SLOT_BITS(16), .NUM_SLOTS(8), .FMT(2)
    ) u_tdm (
        .clk(clk), .rst(rst), .en(en),
        .bclk(c_bclk), .ws(c_ws),
        .bclk_rise(c_rise), .bclk_fall(c_fall),
        .bit_idx(c_bit), .slot_idx(c_slot),
        .frame_start(c_fs)
    );

    int checks   = 0;
    int failures = 0;
    int t        = 0;
    bit valid    = 1'b0;

    typedef struct {
        int bclk;
        int rise;
        int fall;
        int bit_i;
        int slot;
        int ws;
        int fs;
    } exp_t;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    // t = clk edges since the last idle edge; p = BCLK falls so far
    function automatic exp_t model(input int hd, input int sb, input int ns,
                                   input int fmt, input int tt);
        exp_t e;
        int   p;
        bit   edge_now;
        e.bclk   = (tt / hd) % 2;
        edge_now = (tt > 0) && (tt % hd == 0);
        e.rise   = (edge_now && e.bclk == 1) ? 1 : 0;
        e.fall   = (edge_now && e.bclk == 0) ? 1 : 0;
        p        = tt / (2 * hd);
        e.bit_i  = sb - 1 - (p % sb);
        e.slot   = (p / sb) % ns;
        e.fs     = (e.fall == 1 && p % (sb * ns) == 0) ? 1 : 0;
        case (fmt)
            0:       e.ws = (e.slot % 2) ^ ((e.bit_i == 0) ? 1 : 0);
            1:       e.ws = e.slot % 2;
            default: e.ws = (e.slot == ns - 1 && e.bit_i == 0) ? 1 : 0;
        endcase
        return e;
    endfunction

    task automatic check_inst(input string n, input logic b, input logic w,
                              input logic r, input logic f, input logic fs,
                              input logic [31:0] bi, input logic [31:0] si,
                              input exp_t e);
        check_eq({n, ".bclk"}, 32'(b), e.bclk);
        check_eq({n, ".ws"}, 32'(w), e.ws);
        check_eq({n, ".rise"}, 32'(r), e.rise);
        check_eq({n, ".fall"}, 32'(f), e.fall);
        check_eq({n, ".rise_and_fall"}, 32'(r & f), 0);
        check_eq({n, ".bit_idx"}, bi, e.bit_i);
        check_eq({n, ".slot_idx"}, si, e.slot);
        check_eq({n, ".frame_start"}, 32'(fs), e.fs);
    endtask

    task automatic check_all();
        check_inst("i2s", a_bclk, a_ws, a_rise, a_fall, a_fs,
                   32'(a_bit), 32'(a_slot), model(8, 32, 2, 0, t));
        check_inst("lj", b_bclk, b_ws, b_rise, b_fall, b_fs,
                   32'(b_bit), 32'(b_slot), model(8, 32, 2, 1, t));
        check_inst("tdm", c_bclk, c_ws, c_rise, c_fall, c_fs,
                   32'(c_bit), 32'(c_slot), model(2, 16, 8, 2, t));
    endtask

    task automatic step(input logic r, input logic e);
        rst = r;
        en  = e;
        @(posedge clk);
        if (r || !e) begin
            t     = 0;
            valid = 1'b1;
        end else if (valid) begin
            t++;
        end
        #1;
        if (valid) check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1);
    endtask

    initial begin
        int len;
        int kind;
        rst = 1'b1;
        en  = 1'b0;
        repeat (4) step(1'b1, 1'b0);

        // two full I2S frames, one TDM frame set past 4 of its periods
        run(2200);

        // drop en in the middle of slot 1, bit 17 of the I2S frame
        step(1'b1, 1'b0);
        for (int i = 0; i < 1200; i++) begin
            if (((t / 16) % 64) == 46 && (t % 16) == 5) break;
            step(1'b0, 1'b1);
        end
        check_eq("drop_point.bit_idx", 32'(a_bit), 17);
        check_eq("drop_point.slot_idx", 32'(a_slot), 1);
        step(1'b0, 1'b0);
        check_eq("after_drop.bclk", 32'(a_bclk), 0);
        check_eq("after_drop.bit_idx", 32'(a_bit), 31);
        check_eq("after_drop.slot_idx", 32'(a_slot), 0);
        check_eq("after_drop.ws", 32'(a_ws), 0);
        step(1'b0, 1'b0);
        run(300);

        // reset on an edge that would otherwise toggle the HALF_DIV=8 clocks
        for (int i = 0; i < 16; i++) begin
            if ((t % 8) == 7) break;
            step(1'b0, 1'b1);
        end
        step(1'b1, 1'b1);
        check_eq("rst_on_toggle.rise", 32'(a_rise | a_fall), 0);
        check_eq("rst_on_toggle.bclk", 32'(a_bclk), 0);
        run(200);

        for (int k = 0; k < 12; k++) begin
            len  = $urandom_range(50, 1600);
            kind = $urandom_range(0, 2);
            run(len);
            case (kind)
                0: repeat ($urandom_range(1, 5)) step(1'b0, 1'b0);
                1: repeat ($urandom_range(1, 3)) step(1'b1, 1'($urandom_range(0, 1)));
                default: step(1'b1, 1'b0);
            endcase
        end
        run(1100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
